// File: rtl/signed_window_stats_if.sv
// Sample-in / window-statistics-out bundle for signed_window_stats.
// q_avg exists only when SIGNED_WINDOW_STATS_AVG_EN is defined.
interface signed_window_stats_if #(
    parameter int W     = 8,
    parameter int LOG2N = 3
);
    logic                 clear;
    logic                 in_valid;
    logic [W-1:0]         d;
    logic                 out_valid;
    logic [W-1:0]         q_min;
    logic [W-1:0]         q_max;
    logic [W+LOG2N-1:0]   q_sum;
    logic [LOG2N-1:0]     xings;
    logic [LOG2N-1:0]     cnt;
`ifdef SIGNED_WINDOW_STATS_AVG_EN
    logic [W-1:0]         q_avg;
`endif

`ifdef SIGNED_WINDOW_STATS_AVG_EN
    modport master (output clear, in_valid, d,
                    input  out_valid, q_min, q_max, q_sum, xings, cnt, q_avg);
    modport slave  (input  clear, in_valid, d,
                    output out_valid, q_min, q_max, q_sum, xings, cnt, q_avg);
`else
    modport master (output clear, in_valid, d,
                    input  out_valid, q_min, q_max, q_sum, xings, cnt);
    modport slave  (input  clear, in_valid, d,
                    output out_valid, q_min, q_max, q_sum, xings, cnt);
`endif
endinterface

// File: rtl/signed_window_stats.sv
// Signed min/max/sum/sign-change statistics over windows of 2^LOG2N samples.
// Optional q_avg output enabled by defining SIGNED_WINDOW_STATS_AVG_EN.
module signed_window_stats #(
    parameter int W     = 8,
    parameter int LOG2N = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    signed_window_stats_if.slave  bus
);
    localparam int SW = W + LOG2N;
    localparam logic [LOG2N-1:0] LAST = {LOG2N{1'b1}};

    function automatic logic signed [W-1:0] smin(input logic signed [W-1:0] a,
                                                 input logic signed [W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic signed [W-1:0] smax(input logic signed [W-1:0] a,
                                                 input logic signed [W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [LOG2N-1:0]      r_cnt;
    logic signed [W-1:0]   r_min, r_max;
    logic signed [SW-1:0]  r_sum;
    logic [LOG2N-1:0]      r_x;
    logic                  r_prev_sign;
    logic                  r_out_valid;
    logic signed [W-1:0]   r_q_min, r_q_max;
    logic signed [SW-1:0]  r_q_sum;
    logic [LOG2N-1:0]      r_q_x;

    logic                  w_accept, w_first, w_last, w_sign;
    logic signed [W-1:0]   w_d;
    logic signed [SW-1:0]  w_d_ext;
    logic signed [W-1:0]   w_min, w_max;
    logic signed [SW-1:0]  w_sum;
    logic [LOG2N-1:0]      w_x;

    assign w_accept = bus.in_valid & ~bus.clear;
    assign w_first  = (r_cnt == '0);
    assign w_last   = (r_cnt == LAST);
    assign w_d      = bus.d;
    assign w_sign   = w_d[W-1];
    assign w_d_ext  = {{LOG2N{w_d[W-1]}}, w_d};

    // Running values including the current sample; the first sample seeds them.
    assign w_min = w_first ? w_d : smin(r_min, w_d);
    assign w_max = w_first ? w_d : smax(r_max, w_d);
    assign w_sum = w_first ? w_d_ext : (r_sum + w_d_ext);
    assign w_x   = w_first ? '0 :
                   (r_x + {{(LOG2N-1){1'b0}}, (w_sign != r_prev_sign)});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_min       <= '0;
            r_max       <= '0;
            r_sum       <= '0;
            r_x         <= '0;
            r_prev_sign <= 1'b0;
            r_out_valid <= 1'b0;
            r_q_min     <= '0;
            r_q_max     <= '0;
            r_q_sum     <= '0;
            r_q_x       <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (bus.clear) begin
                r_cnt <= '0;
                r_min <= '0;
                r_max <= '0;
                r_sum <= '0;
                r_x   <= '0;
            end else if (w_accept) begin
                r_cnt       <= r_cnt + 1'b1;
                r_min       <= w_min;
                r_max       <= w_max;
                r_sum       <= w_sum;
                r_x         <= w_x;
                r_prev_sign <= w_sign;
                if (w_last) begin
                    r_out_valid <= 1'b1;
                    r_q_min     <= w_min;
                    r_q_max     <= w_max;
                    r_q_sum     <= w_sum;
                    r_q_x       <= w_x;
                end
            end
        end
    end

`ifdef SIGNED_WINDOW_STATS_AVG_EN
    logic signed [SW-1:0] w_avg_full;
    logic signed [W-1:0]  r_q_avg;

    // Arithmetic shift floors toward -inf; the result always fits in W bits.
    assign w_avg_full = w_sum >>> LOG2N;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q_avg <= '0;
        end else if (w_accept && w_last) begin
            r_q_avg <= w_avg_full[W-1:0];
        end
    end

    assign bus.q_avg = r_q_avg;
`endif

    assign bus.out_valid = r_out_valid;
    assign bus.q_min     = r_q_min;
    assign bus.q_max     = r_q_max;
    assign bus.q_sum     = r_q_sum;
    assign bus.xings     = r_q_x;
    assign bus.cnt       = r_cnt;
endmodule

// File: tb/tb_signed_window_stats.sv
// Directed-vector bench for signed_window_stats (W=8, LOG2N=3).
module tb_signed_window_stats;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   pulses  = 0;

    always #5 clk = ~clk;

    signed_window_stats_if #(.W(8), .LOG2N(3)) bus ();

    signed_window_stats #(.W(8), .LOG2N(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, settle 1ns, tally publish pulses.
    task automatic cyc(input logic v, input logic c, input logic [7:0] dv);
        bus.in_valid = v;
        bus.clear    = c;
        bus.d        = dv;
        @(posedge clk);
        #1;
        if (bus.out_valid === 1'b1) pulses++;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_res(input string tag, input logic [7:0] mn, input logic [7:0] mx,
                             input logic [10:0] sm, input logic [2:0] x, input logic [7:0] av);
        check({tag, ".min"},   {24'b0, bus.q_min}, {24'b0, mn});
        check({tag, ".max"},   {24'b0, bus.q_max}, {24'b0, mx});
        check({tag, ".sum"},   {21'b0, bus.q_sum}, {21'b0, sm});
        check({tag, ".xings"}, {29'b0, bus.xings}, {29'b0, x});
`ifdef SIGNED_WINDOW_STATS_AVG_EN
        check({tag, ".avg"},   {24'b0, bus.q_avg}, {24'b0, av});
`else
        if (av !== av) n_fail++;
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] alt [0:7];
        bus.in_valid = 1'b0;
        bus.clear    = 1'b0;
        bus.d        = 8'h00;

        // Reset state
        #2;
        check("rst.out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst.cnt", {29'b0, bus.cnt}, 32'd0);
        check_res("rst", 8'h00, 8'h00, 11'h000, 3'd0, 8'h00);
        #16 rst = 1'b1;
        idle();

        // Ramp 0..7
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'(i));
        check("ramp.cnt7", {29'b0, bus.cnt}, 32'd7);
        check("ramp.no_early_pulse", {31'b0, bus.out_valid}, 32'd0);
        cyc(1'b1, 1'b0, 8'd7);
        check("ramp.out_valid", {31'b0, bus.out_valid}, 32'd1);
        check("ramp.cnt_wrap", {29'b0, bus.cnt}, 32'd0);
        check_res("ramp", 8'h00, 8'h07, 11'd28, 3'd0, 8'h03);
        idle();
        check("ramp.pulse_one_cycle", {31'b0, bus.out_valid}, 32'd0);
        check("ramp.hold_sum", {21'b0, bus.q_sum}, 32'd28);

        // Eight samples of -19
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'hED);
        check("neg.out_valid", {31'b0, bus.out_valid}, 32'd1);
        check_res("neg", 8'hED, 8'hED, 11'h768, 3'd0, 8'hED);

        // Alternating +1/-1 then 127/-128 back-to-back
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, (i % 2 == 0) ? 8'h01 : 8'hFF);
        check("alt1.out_valid", {31'b0, bus.out_valid}, 32'd1);
        check_res("alt1", 8'hFF, 8'h01, 11'h000, 3'd7, 8'h00);
        for (int i = 0; i < 8; i++) alt[i] = (i % 2 == 0) ? 8'h7F : 8'h80;
        pulses = 0;
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, alt[i]);
        check("alt2.no_pulse_7", pulses, 32'd0);
        cyc(1'b1, 1'b0, alt[7]);
        check("alt2.out_valid_8", {31'b0, bus.out_valid}, 32'd1);
        check_res("alt2", 8'h80, 8'h7F, 11'h7FC, 3'd7, 8'hFF);

        // Partial window aborted by clear (with a colliding sample), then full window of 3
        idle();
        pulses = 0;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'd9);
        check("clr.cnt5", {29'b0, bus.cnt}, 32'd5);
        cyc(1'b1, 1'b1, 8'd9);
        check("clr.cnt0", {29'b0, bus.cnt}, 32'd0);
        check("clr.out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("clr.hold_sum", {21'b0, bus.q_sum}, 32'h7FC);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'd3);
        check("clr.out_valid_after", {31'b0, bus.out_valid}, 32'd1);
        idle();
        check("clr.one_pulse", pulses, 32'd1);
        check_res("clr", 8'h03, 8'h03, 11'd24, 3'd0, 8'h03);

        // Clear on the cycle that would be the 8th sample: no publish
        pulses = 0;
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'd1);
        cyc(1'b1, 1'b1, 8'd1);
        idle();
        check("clr8.no_pulse", pulses, 32'd0);
        check("clr8.hold_sum", {21'b0, bus.q_sum}, 32'd24);

        // Gaps in in_valid; -5 -> 0 counts as a change since zero is non-negative
        cyc(1'b1, 1'b0, 8'd5);  idle();
        check("gap.cnt_hold", {29'b0, bus.cnt}, 32'd1);
        cyc(1'b1, 1'b0, 8'hFB); idle();
        cyc(1'b1, 1'b0, 8'd0);  idle(); idle();
        check("gap.cnt_hold3", {29'b0, bus.cnt}, 32'd3);
        cyc(1'b1, 1'b0, 8'd0);  idle();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'd1);
        check("gap.out_valid", {31'b0, bus.out_valid}, 32'd1);
        check_res("gap", 8'hFB, 8'h05, 11'd4, 3'd2, 8'h00);

        // Asynchronous reset mid-window, away from the clock edge
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'd4);
        #3 rst = 1'b0;
        #1;
        check("arst.cnt", {29'b0, bus.cnt}, 32'd0);
        check("arst.out_valid", {31'b0, bus.out_valid}, 32'd0);
        check_res("arst", 8'h00, 8'h00, 11'h000, 3'd0, 8'h00);
        #2 rst = 1'b1;
        begin
            logic [7:0] v8 [0:7];
            v8[0] = 8'd10;  v8[1] = 8'hEC; v8[2] = 8'd30;  v8[3] = 8'hD8;
            v8[4] = 8'd50;  v8[5] = 8'hC4; v8[6] = 8'd70;  v8[7] = 8'hB0;
            for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, v8[i]);
        end
        check("post.out_valid", {31'b0, bus.out_valid}, 32'd1);
        check_res("post", 8'hB0, 8'h46, 11'h7D8, 3'd7, 8'hFB);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
